// File: rtl/eth_pkg.sv
// Shared constants, record type and byte-order helpers for the Ethernet ARP receive path.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

    localparam logic [3:0] W_DST_LO   = 4'd0;
    localparam logic [3:0] W_DST_HI   = 4'd1;
    localparam logic [3:0] W_ETYPE    = 4'd3;
    localparam logic [3:0] W_PTYPE    = 4'd4;
    localparam logic [3:0] W_OPER     = 4'd5;
    localparam logic [3:0] W_SHA_LO   = 4'd6;
    localparam logic [3:0] W_SPA      = 4'd7;
    localparam logic [3:0] W_TPA_HI   = 4'd9;
    localparam logic [3:0] W_TPA_LAST = 4'd10;
    localparam logic [3:0] CNT_MAX    = 4'd15;

    typedef enum logic [0:0] {
        ST_RECV  = 1'b0,
        ST_DRAIN = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
    } arp_rec_t;

    // Lane 0 is the earliest wire byte, so network-order fields arrive byte-reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/eth_arp_rx_outreg.sv
// Single-entry valid/ready record holder; flags records it had to drop because it was full.
module eth_arp_rx_outreg
    import eth_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     load,
    input  arp_rec_t rec,
    input  logic     ready,
    output logic     valid,
    output arp_rec_t held_rec,
    output logic     drop,
    output logic     loaded
);

    logic     valid_r;
    logic     drop_r;
    logic     loaded_r;
    arp_rec_t rec_r;

    // Holding register: a completing handshake frees the slot in the same cycle a new record arrives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r  <= 1'b0;
            drop_r   <= 1'b0;
            loaded_r <= 1'b0;
            rec_r    <= '0;
        end else begin
            drop_r   <= 1'b0;
            loaded_r <= 1'b0;
            if (load) begin
                if (!valid_r || ready) begin
                    rec_r    <= rec;
                    valid_r  <= 1'b1;
                    loaded_r <= 1'b1;
                end else begin
                    drop_r <= 1'b1;
                end
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign valid    = valid_r;
    assign held_rec = rec_r;
    assign drop     = drop_r;
    assign loaded   = loaded_r;

endmodule

// File: rtl/eth_arp_rx.sv
// ARP receive filter on a 32-bit MAC RX stream; emits one record per ARP packet for the local IP.
// Optional statistics counters are enabled by defining ETH_ARP_RX_STATS_EN.
module eth_arp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC    = 48'h00_0A_35_00_01_02,
    parameter logic [31:0] LOCAL_IP     = 32'hC0A8010A,
    parameter bit          ACCEPT_REPLY = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        arp_valid,
    input  logic        arp_ready,
    output logic [15:0] arp_oper,
    output logic [47:0] arp_sha,
    output logic [31:0] arp_spa
`ifdef ETH_ARP_RX_STATS_EN
    ,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_arp_ok,
    output logic [15:0] stat_drop,
    output logic [15:0] stat_bad
`endif
);

    rx_state_t   state_r;
    logic [3:0]  cnt_r;
    logic        match_r;
    logic        keep_ok_r;
    logic        dst_u_r;
    logic        dst_b_r;
    logic        tready_r;
    arp_rec_t    shadow_r;

    logic        beat_s;
    logic        field_ok_s;
    logic        match_next_s;
    logic        keep_next_s;
    logic        accept_s;
    logic        bad_s;
    logic        dst_u0_s;
    logic        dst_b0_s;
    logic [15:0] oper_s;
    logic        drop_s;
    logic        loaded_s;
    logic        valid_s;
    arp_rec_t    held_s;
    logic        unused_keep_s;

    assign beat_s        = s_axis_tvalid && tready_r;
    assign s_axis_tready = tready_r;
    assign oper_s        = bswap16(s_axis_tdata[15:0]);
    assign dst_u0_s      = (s_axis_tdata == bswap32(LOCAL_MAC[47:16]));
    assign dst_b0_s      = (s_axis_tdata == 32'hFFFF_FFFF);
    assign unused_keep_s = ^s_axis_tkeep[3:2];

    // Per-word field check; words carrying no checked field always pass.
    always_comb begin
        field_ok_s = 1'b1;
        case (cnt_r)
            W_DST_LO:   field_ok_s = dst_u0_s || dst_b0_s;
            W_DST_HI:   field_ok_s = (dst_u_r && (s_axis_tdata[15:0] == bswap16(LOCAL_MAC[15:0])))
                                  || (dst_b_r && (s_axis_tdata[15:0] == 16'hFFFF));
            W_ETYPE:    field_ok_s = (s_axis_tdata == {bswap16(ARP_HTYPE_ETH), bswap16(ETHERTYPE_ARP)});
            W_PTYPE:    field_ok_s = (s_axis_tdata == {ARP_PLEN_IPV4, ARP_HLEN_ETH, bswap16(ARP_PTYPE_IPV4)});
            W_OPER:     field_ok_s = (oper_s == ARP_OPER_REQ)
                                  || (ACCEPT_REPLY && (oper_s == ARP_OPER_REP));
            W_TPA_HI:   field_ok_s = (s_axis_tdata[31:16] == bswap16(LOCAL_IP[31:16]));
            W_TPA_LAST: field_ok_s = (s_axis_tdata[15:0] == bswap16(LOCAL_IP[15:0]));
            default:    field_ok_s = 1'b1;
        endcase
    end

    // Frame verdict for the current beat, including the check on the beat itself.
    always_comb begin
        match_next_s = match_r && field_ok_s;
        keep_next_s  = (cnt_r == W_TPA_LAST) ? (s_axis_tkeep[1:0] == 2'b11) : keep_ok_r;
        accept_s     = beat_s && s_axis_tlast && (state_r == ST_RECV) && match_next_s
                    && keep_next_s && (cnt_r >= W_TPA_LAST) && !s_axis_tuser;
        bad_s        = beat_s && s_axis_tlast && (s_axis_tuser || (cnt_r < W_TPA_LAST));
    end

    // Parser FSM, word counter and shadow capture of the ARP fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_RECV;
            cnt_r     <= 4'd0;
            match_r   <= 1'b1;
            keep_ok_r <= 1'b0;
            dst_u_r   <= 1'b0;
            dst_b_r   <= 1'b0;
            tready_r  <= 1'b0;
            shadow_r  <= '0;
        end else begin
            tready_r <= 1'b1;
            if (beat_s) begin
                if (s_axis_tlast) begin
                    state_r   <= ST_RECV;
                    cnt_r     <= 4'd0;
                    match_r   <= 1'b1;
                    keep_ok_r <= 1'b0;
                end else begin
                    cnt_r <= (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + 4'd1;
                    case (state_r)
                        ST_RECV: begin
                            match_r   <= match_next_s;
                            keep_ok_r <= keep_next_s;
                            if (cnt_r == W_DST_LO) begin
                                dst_u_r <= dst_u0_s;
                                dst_b_r <= dst_b0_s;
                            end
                            if (cnt_r == W_OPER) begin
                                shadow_r.oper       <= oper_s;
                                shadow_r.sha[47:32] <= bswap16(s_axis_tdata[31:16]);
                            end
                            if (cnt_r == W_SHA_LO) begin
                                shadow_r.sha[31:0] <= bswap32(s_axis_tdata);
                            end
                            if (cnt_r == W_SPA) begin
                                shadow_r.spa <= bswap32(s_axis_tdata);
                            end
                            if (!match_next_s) begin
                                state_r <= ST_DRAIN;
                            end
                        end
                        ST_DRAIN: state_r <= ST_DRAIN;
                        default:  state_r <= ST_RECV;
                    endcase
                end
            end
        end
    end

    eth_arp_rx_outreg u_outreg (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept_s),
        .rec      (shadow_r),
        .ready    (arp_ready),
        .valid    (valid_s),
        .held_rec (held_s),
        .drop     (drop_s),
        .loaded   (loaded_s)
    );

    assign arp_valid = valid_s;
    assign arp_oper  = held_s.oper;
    assign arp_sha   = held_s.sha;
    assign arp_spa   = held_s.spa;

`ifdef ETH_ARP_RX_STATS_EN
    // Free-running event counters; they wrap on overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_frames <= 32'd0;
            stat_arp_ok <= 32'd0;
            stat_drop   <= 16'd0;
            stat_bad    <= 16'd0;
        end else begin
            if (beat_s && s_axis_tlast) stat_frames <= stat_frames + 32'd1;
            if (loaded_s)               stat_arp_ok <= stat_arp_ok + 32'd1;
            if (drop_s)                 stat_drop   <= stat_drop + 16'd1;
            if (bad_s)                  stat_bad    <= stat_bad + 16'd1;
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = drop_s ^ loaded_s ^ bad_s;
`endif

endmodule

// File: tb/tb_eth_arp_rx.sv
// Self-checking bench for eth_arp_rx: directed scenarios plus randomized frames against a byte-level model.
module tb_eth_arp_rx;

    localparam logic [47:0] LMAC = 48'h000A35000102;
    localparam logic [31:0] LIP  = 32'hC0A8010A;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        arp_valid;
    logic        arp_ready;
    logic [15:0] arp_oper;
    logic [47:0] arp_sha;
    logic [31:0] arp_spa;
`ifdef ETH_ARP_RX_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_arp_ok;
    logic [15:0] stat_drop;
    logic [15:0] stat_bad;
`endif

    always #5 clk = ~clk;

    eth_arp_rx dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .arp_valid     (arp_valid),
        .arp_ready     (arp_ready),
        .arp_oper      (arp_oper),
        .arp_sha       (arp_sha),
        .arp_spa       (arp_spa)
`ifdef ETH_ARP_RX_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_arp_ok   (stat_arp_ok),
        .stat_drop     (stat_drop),
        .stat_bad      (stat_bad)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Frame under construction: words in wire order, lane 0 first.
    logic [31:0] fw [0:15];
    int          fn;
    logic [3:0]  fkeep_last;

    // Expected state of the output register and event counts.
    bit          exp_valid;
    logic [15:0] exp_oper;
    logic [47:0] exp_sha;
    logic [31:0] exp_spa;
    int exp_frames, exp_ok, exp_drop, exp_bad;

    // Byte-level ARP acceptance rules applied to the frame as a plain byte string.
    function automatic bit model_accept(input bit tu, output logic [15:0] op,
                                        output logic [47:0] sha, output logic [31:0] spa);
        logic [7:0]  b [0:63];
        logic [47:0] dst;
        logic [31:0] tpa;
        int          len;
        for (int i = 0; i < 64; i++) b[i] = fw[i / 4][8 * (i % 4) +: 8];
        len = 4 * (fn - 1) + ((fkeep_last == 4'hF) ? 4 : (fkeep_last == 4'h7) ? 3 :
                              (fkeep_last == 4'h3) ? 2 : 1);
        dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
        op  = {b[20], b[21]};
        sha = {b[22], b[23], b[24], b[25], b[26], b[27]};
        spa = {b[28], b[29], b[30], b[31]};
        tpa = {b[38], b[39], b[40], b[41]};
        return !tu && (len >= 42) && (dst == LMAC || dst == 48'hFFFF_FFFF_FFFF)
            && ({b[12], b[13]} == 16'h0806) && ({b[14], b[15]} == 16'h0001)
            && ({b[16], b[17]} == 16'h0800) && (b[18] == 8'd6) && (b[19] == 8'd4)
            && (op == 16'd1 || op == 16'd2) && (tpa == LIP);
    endfunction

    task automatic build_good();
        for (int i = 0; i < 16; i++) fw[i] = 32'h0;
        fw[0]  = 32'hFFFF_FFFF;
        fw[1]  = 32'hE000_FFFF;
        fw[2]  = 32'hBDA1_684C;
        fw[3]  = 32'h0100_0608;
        fw[4]  = 32'h0406_0008;
        fw[5]  = 32'hE000_0100;
        fw[6]  = 32'hBDA1_684C;
        fw[7]  = 32'h8101_A8C0;
        fw[9]  = 32'hA8C0_0000;
        fw[10] = 32'h0000_0A01;
        fn         = 11;
        fkeep_last = 4'h3;
    endtask

    // Drives the frame in fw[] and advances the expected output/counter state.
    task automatic send_frame(input bit tu, input int bubble_pct, input bit ready_on_last);
        bit acc, hs;
        logic [15:0] op;
        logic [47:0] sha;
        logic [31:0] spa;
        for (int w = 0; w < fn; w++) begin
            while ($urandom_range(99) < bubble_pct) begin
                s_axis_tvalid = 1'b0;
                @(negedge clk);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fw[w];
            s_axis_tkeep  = (w == fn - 1) ? fkeep_last : 4'hF;
            s_axis_tlast  = (w == fn - 1);
            s_axis_tuser  = (w == fn - 1) ? tu : 1'b0;
            arp_ready     = (w == fn - 1) ? ready_on_last : 1'b0;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        arp_ready     = 1'b0;
        acc = model_accept(tu, op, sha, spa);
        hs  = exp_valid && ready_on_last;
        exp_frames++;
        if (tu || fn < 11) exp_bad++;
        if (acc) begin
            if (!exp_valid || hs) begin
                exp_valid = 1'b1;
                exp_oper  = op;
                exp_sha   = sha;
                exp_spa   = spa;
                exp_ok++;
            end else begin
                exp_drop++;
            end
        end else if (hs) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic pop();
        arp_ready = 1'b1;
        @(negedge clk);
        arp_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_axis_tready, arp_valid, arp_oper, arp_sha, arp_spa} !== 98'd0) begin
            errors++;
            $display("FAIL reset_values: got tready=%0b valid=%0b oper=%h sha=%h spa=%h, want all zero",
                     s_axis_tready, arp_valid, arp_oper, arp_sha, arp_spa);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %0b want 1", s_axis_tready);
        end
    endtask

    task automatic test_broadcast();
        build_good();
        send_frame(1'b0, 0, 1'b0);
        checks++;
        if (arp_valid !== 1'b1 || arp_oper !== 16'd1 || arp_spa !== 32'hC0A80181 ||
            arp_sha !== 48'h00E04C68A1BD) begin
            errors++;
            $display("FAIL broadcast_req: got v=%0b oper=%h sha=%h spa=%h want v=1 oper=0001 sha=00e04c68a1bd spa=c0a80181",
                     arp_valid, arp_oper, arp_sha, arp_spa);
        end
        pop();
        checks++;
        if (arp_valid !== 1'b0) begin
            errors++;
            $display("FAIL broadcast_pop: got valid=%0b want 0", arp_valid);
        end
    endtask

    task automatic test_mismatch();
        build_good();
        fw[10] = 32'h0000_0B01;
        send_frame(1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (arp_valid !== exp_valid) begin
            errors++;
            $display("FAIL tpa_mismatch: got valid=%0b want %0b", arp_valid, exp_valid);
        end
        build_good();
        send_frame(1'b0, 0, 1'b0);
        checks++;
        if (arp_valid !== exp_valid || {arp_oper, arp_sha, arp_spa} !== {exp_oper, exp_sha, exp_spa}) begin
            errors++;
            $display("FAIL after_mismatch: got v=%0b rec=%h want v=%0b rec=%h",
                     arp_valid, {arp_oper, arp_sha, arp_spa}, exp_valid, {exp_oper, exp_sha, exp_spa});
        end
        pop();
    endtask

    task automatic test_bad_frames();
        build_good();
        send_frame(1'b1, 0, 1'b0);
        checks++;
        if (arp_valid !== 1'b0) begin
            errors++;
            $display("FAIL tuser_frame: got valid=%0b want 0", arp_valid);
        end
        build_good();
        fn         = 9;
        fkeep_last = 4'hF;
        send_frame(1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (arp_valid !== 1'b0) begin
            errors++;
            $display("FAIL runt_frame: got valid=%0b want 0", arp_valid);
        end
`ifdef ETH_ARP_RX_STATS_EN
        checks++;
        if (stat_bad !== exp_bad[15:0]) begin
            errors++;
            $display("FAIL stat_bad: got %0d want %0d", stat_bad, exp_bad);
        end
`endif
    endtask

    task automatic test_back_to_back();
        build_good();
        send_frame(1'b0, 0, 1'b0);
        build_good();
        fw[7] = 32'h0201_A8C0;
        send_frame(1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (arp_valid !== 1'b1 || arp_spa !== 32'hC0A80181 || {arp_oper, arp_sha, arp_spa} !== {exp_oper, exp_sha, exp_spa}) begin
            errors++;
            $display("FAIL held_record: got v=%0b spa=%h want v=1 spa=c0a80181", arp_valid, arp_spa);
        end
`ifdef ETH_ARP_RX_STATS_EN
        checks++;
        if (stat_drop !== exp_drop[15:0]) begin
            errors++;
            $display("FAIL stat_drop: got %0d want %0d", stat_drop, exp_drop);
        end
`endif
        pop();
        checks++;
        if (arp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_after_ready: got valid=%0b want 0", arp_valid);
        end
        // Full register, handshake on the same edge as the new record arrives.
        build_good();
        send_frame(1'b0, 0, 1'b0);
        build_good();
        fw[7] = 32'h0301_A8C0;
        send_frame(1'b0, 0, 1'b1);
        checks++;
        if (arp_valid !== 1'b1 || arp_spa !== 32'hC0A80103 || arp_spa !== exp_spa) begin
            errors++;
            $display("FAIL load_with_handshake: got v=%0b spa=%h want v=1 spa=c0a80103", arp_valid, arp_spa);
        end
        pop();
    endtask

    task automatic test_padded();
        build_good();
        fw[0] = 32'h0035_0A00;
        fw[1] = 32'hE000_0201;
        fn    = 15;
        fkeep_last = 4'hF;
        for (int i = 11; i < 15; i++) fw[i] = $urandom;
        send_frame(1'b0, 30, 1'b0);
        checks++;
        if (arp_valid !== 1'b1 || arp_oper !== 16'd1 || arp_spa !== 32'hC0A80181 ||
            arp_sha !== 48'h00E04C68A1BD) begin
            errors++;
            $display("FAIL padded_unicast: got v=%0b oper=%h sha=%h spa=%h", arp_valid, arp_oper, arp_sha, arp_spa);
        end
        pop();
    endtask

    task automatic test_random();
        logic [15:0] op;
        bit tu;
        for (int n = 0; n < 30; n++) begin
            build_good();
            case ($urandom_range(2))
                0: begin fw[0] = 32'h0035_0A00; fw[1][15:0] = 16'h0201; end
                1: fw[0] = $urandom | 32'h1;
                default: fw[0] = 32'hFFFF_FFFF;
            endcase
            op = 16'($urandom_range(3, 1));
            fw[5] = {16'($urandom), op[7:0], op[15:8]};
            fw[6] = $urandom;
            fw[7] = $urandom;
            if ($urandom_range(4) == 0) fw[10][15:8] = fw[10][15:8] ^ 8'h01;
            if ($urandom_range(7) == 0) fw[3][7:0] = 8'h00;
            fn = $urandom_range(15, 9);
            for (int i = 11; i < 16; i++) fw[i] = $urandom;
            fkeep_last = (fn == 11 && $urandom_range(1) == 0) ? 4'h3 : 4'hF;
            tu = ($urandom_range(7) == 0);
            send_frame(tu, 20, 1'b0);
            checks++;
            if (arp_valid !== exp_valid ||
                (exp_valid && {arp_oper, arp_sha, arp_spa} !== {exp_oper, exp_sha, exp_spa})) begin
                errors++;
                $display("FAIL random_frame_%0d: got v=%0b rec=%h want v=%0b rec=%h", n,
                         arp_valid, {arp_oper, arp_sha, arp_spa}, exp_valid, {exp_oper, exp_sha, exp_spa});
            end
            if (exp_valid) pop();
        end
    endtask

    task automatic test_stats();
        repeat (2) @(negedge clk);
`ifdef ETH_ARP_RX_STATS_EN
        checks++;
        if (stat_frames !== 32'(exp_frames) || stat_arp_ok !== 32'(exp_ok) ||
            stat_drop !== 16'(exp_drop) || stat_bad !== 16'(exp_bad)) begin
            errors++;
            $display("FAIL stats: got frames=%0d ok=%0d drop=%0d bad=%0d want %0d %0d %0d %0d",
                     stat_frames, stat_arp_ok, stat_drop, stat_bad, exp_frames, exp_ok, exp_drop, exp_bad);
        end
`endif
    endtask

    task automatic test_reset_mid();
        build_good();
        send_frame(1'b0, 0, 1'b0);
        build_good();
        for (int w = 0; w < 7; w++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fw[w];
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = 1'b0;
            if (w == 6) resetn = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (arp_valid !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL during_reset: got valid=%0b tready=%0b want 0 0", arp_valid, s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
        resetn = 1'b1;
        exp_valid = 1'b0;
        exp_frames = 0; exp_ok = 0; exp_drop = 0; exp_bad = 0;
        @(negedge clk);
        checks++;
        if (arp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got valid=%0b want 0", arp_valid);
        end
        build_good();
        send_frame(1'b0, 0, 1'b0);
        checks++;
        if (arp_valid !== 1'b1 || {arp_oper, arp_sha, arp_spa} !== {exp_oper, exp_sha, exp_spa}) begin
            errors++;
            $display("FAIL post_reset_frame: got v=%0b rec=%h want v=1 rec=%h",
                     arp_valid, {arp_oper, arp_sha, arp_spa}, {exp_oper, exp_sha, exp_spa});
        end
        pop();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (arp_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_record_%0d: got valid=%0b want 0", i, arp_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tkeep  = 4'h0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        arp_ready     = 1'b0;
        exp_valid     = 1'b0;
        exp_oper = 16'h0; exp_sha = 48'h0; exp_spa = 32'h0;
        exp_frames = 0; exp_ok = 0; exp_drop = 0; exp_bad = 0;
        test_reset();
        test_broadcast();
        test_mismatch();
        test_bad_frames();
        test_back_to_back();
        test_padded();
        test_random();
        test_stats();
        test_reset_mid();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
